regfile_write_arbiter: RTL

//  Shares the register file's single write port between the pipeline WB stage
//  and the long-latency mul/div result path. Buffers aux results in a small

---
 rtl/regfile_write_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter: pipeline WB writes have priority, mul/div results queue in a small FIFO.
// Define REGFILE_ARB_STARVE_EN to enable the forced aux grant after STARVE_LIMIT losing cycles.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int AUX_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pipeValid,
    output logic                             pipeReady,
    input  logic [ADDR_WIDTH-1:0]            pipeAddr,
    input  logic [DATA_WIDTH-1:0]            pipeData,
    input  logic                             auxValid,
    output logic                             auxReady,
    input  logic [ADDR_WIDTH-1:0]            auxAddr,
    input  logic [DATA_WIDTH-1:0]            auxData,
    output logic                             regWrite,
    output logic [ADDR_WIDTH-1:0]            writeAddress,
    output logic [DATA_WIDTH-1:0]            writeData,
    output logic [$clog2(AUX_DEPTH+1)-1:0]   auxCount
);

    localparam int PTR_W = $clog2(AUX_DEPTH);
    localparam int CNT_W = $clog2(AUX_DEPTH + 1);

    typedef enum logic {ST_ARB, ST_FORCE} state_t;

    state_t                  state;
    logic [AUX_DEPTH-1:0]    ent_valid;
    logic [ADDR_WIDTH-1:0]   ent_addr [AUX_DEPTH];
    logic [DATA_WIDTH-1:0]   ent_data [AUX_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;

    logic                    empty;
    logic                    full;
    logic                    store;
    logic                    pipe_grant;
    logic                    aux_pop;
    logic                    squash;
    logic                    write_en;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic [DATA_WIDTH-1:0]   grant_data;

    assign empty      = (auxCount == '0);
    assign full       = (auxCount == CNT_W'(AUX_DEPTH));
    assign auxReady   = !full;
    assign pipeReady  = (state == ST_ARB);
    assign store      = auxValid && !full && (auxAddr != '0);
    assign pipe_grant = pipeReady && pipeValid;
    // In FORCE pipe_grant is 0, so the head is granted whenever one exists.
    assign aux_pop    = !empty && !pipe_grant;
    assign squash     = pipe_grant && (pipeAddr != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_addr = pipeAddr;
        grant_data = pipeData;
        write_en   = squash;
        if (aux_pop) begin
            grant_addr = ent_addr[rd_ptr];
            grant_data = ent_data[rd_ptr];
            write_en   = ent_valid[rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            auxCount  <= '0;
        end else begin
            if (squash) begin
                for (int i = 0; i < AUX_DEPTH; i++) begin
                    if (ent_addr[i] == pipeAddr) ent_valid[i] <= 1'b0;
                end
            end
            // A same-cycle push to the squashed register is stored already dead.
            if (store) begin
                ent_valid[wr_ptr] <= !(squash && (auxAddr == pipeAddr));
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (aux_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({store, aux_pop})
                2'b10:   auxCount <= auxCount + CNT_W'(1);
                2'b01:   auxCount <= auxCount - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the payload array has no reset; occupancy and valid bits decide what is meaningful.
    always_ff @(posedge clk) begin
        if (store) begin
            ent_addr[wr_ptr] <= auxAddr;
            ent_data[wr_ptr] <= auxData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite     <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
        end else begin
            regWrite <= write_en;
            if (write_en) begin
                writeAddress <= grant_addr;
                writeData    <= grant_data;
            end
        end
    end

`ifdef REGFILE_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    // FORCE is entered on the same edge the counter would reach the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ARB;
            starve_cnt <= '0;
        end else begin
            state <= ST_ARB;
            if (aux_pop) begin
                starve_cnt <= '0;
            end else if (pipe_grant && !empty) begin
                if (starve_cnt + SW'(1) == SW'(STARVE_LIMIT)) begin
                    starve_cnt <= '0;
                    state      <= ST_FORCE;
                end else begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ARB;
        else        state <= ST_ARB;
    end
`endif

endmodule
